// File: rtl/parity_frame_receiver.sv
// -----------------------------------------------------------------------------
// parity_frame_receiver
//
// Serial receiver placed after the 3-bit even-parity generator/checker stage.
// It deserializes a start/data/parity/stop frame sampled on bit_en strobes,
// re-checks even parity over data plus parity bit, and presents the word with
// a one-clock valid strobe and parity/framing error flags.
//
// Optional feature macro: PARITY_ERR_CNT_EN
//   defined   -> saturating counter of bad frames drives err_cnt
//   undefined -> no counter logic, err_cnt tied to 0 (port list unchanged)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   bit_en      in   bit strobe; sdi sampled only when high
//   sdi         in   serial data, idles at 1
//   data_out    out  last received word, first data bit in bit 0
//   data_valid  out  one-clock pulse when data_out/flags update
//   parity_err  out  XOR of received data and parity bit was 1
//   frame_err   out  stop bit sampled as 0
//   err_cnt     out  saturating count of frames with any error
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for a start bit (sdi=0 on a strobe)
// DATA   | collecting DATA_W data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | sampling stop bit, publishing word and flags
// -----------------------------------------------------------------------------
module parity_frame_receiver #(
   parameter int DATA_W    = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_en,
   input  logic                 sdi,
   output logic [DATA_W-1:0]    data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      dout_d  = dout_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      valid_d = 1'b0;

      if (bit_en) begin
         case (state_q)
            S_IDLE: begin
               if (!sdi) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               // Compare-based write keeps the index in range for any DATA_W.
               for (int i = 0; i < DATA_W; i++) begin
                  if (cnt_q == CNT_W'(i)) shift_d[i] = sdi;
               end
               if (cnt_q == LAST_IDX) begin
                  state_d = S_PARITY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_PARITY: begin
               par_d   = sdi;
               state_d = S_STOP;
            end
            S_STOP: begin
               // A bad stop bit still delivers the word and is never
               // reinterpreted as the next start bit.
               dout_d  = shift_q;
               perr_d  = (^shift_q) ^ par_q;
               ferr_d  = ~sdi;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

`ifdef PARITY_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Counts on the same edge that raises data_valid, using the flags being
   // published for that frame; holds at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (valid_d && (perr_d || ferr_d) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_frame_receiver.sv
module tb_parity_frame_receiver;

   localparam int DATA_W = 3;
   localparam int ERR_W  = 2;

   logic              clk;
   logic              rst;
   logic              bit_en;
   logic              sdi;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic [ERR_W-1:0]  err_cnt;

   int checks;
   int errors;
   int dv_count;
   int pulses;

   parity_frame_receiver #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .sdi        (sdi),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected counter value after n bad frames since reset.
   function automatic int exp_cnt(input int n);
`ifdef PARITY_ERR_CNT_EN
      return (n > 3) ? 3 : n;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives six bits, f[5] first, one per cycle with bit_en high, then drops
   // bit_en. Returns on the negedge after the stop bit was sampled.
   task automatic send_frame(input string tag, input logic [5:0] f);
      int early;
      early = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (data_valid) early++;
         bit_en = 1'b1;
         sdi    = f[5-i];
      end
      @(negedge clk);
      bit_en = 1'b0;
      sdi    = 1'b1;
      check({tag, "_dv_early"}, early, 0);
   endtask

   task automatic expect_frame(input string tag, input int d, input int pe,
                               input int fe, input int ec);
      check({tag, "_dv"},   int'(data_valid), 1);
      check({tag, "_data"}, int'(data_out),   d);
      check({tag, "_perr"}, int'(parity_err), pe);
      check({tag, "_ferr"}, int'(frame_err),  fe);
      check({tag, "_cnt"},  int'(err_cnt),    ec);
      @(negedge clk);
      check({tag, "_dv_off"},    int'(data_valid), 0);
      check({tag, "_data_hold"}, int'(data_out),   d);
   endtask

   initial begin
      logic [5:0]  gap_bits;
      logic [29:0] sat_bits;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bit_en = 1'b0;
      sdi    = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_data", int'(data_out),   0);
      check("rst_dv",   int'(data_valid), 0);
      check("rst_perr", int'(parity_err), 0);
      check("rst_ferr", int'(frame_err),  0);
      check("rst_cnt",  int'(err_cnt),    0);
      rst = 1'b0;

      // Idle line with strobe every cycle.
      dv_count = 0;
      repeat (20) begin
         @(negedge clk);
         bit_en = 1'b1;
         sdi    = 1'b1;
         if (data_valid) dv_count++;
      end
      @(negedge clk);
      bit_en = 1'b0;
      if (data_valid) dv_count++;
      check("idle_dv_count", dv_count, 0);
      check("idle_data", int'(data_out), 0);
      check("idle_flags", int'({parity_err, frame_err}), 0);

      send_frame("good", 6'b010101);
      expect_frame("good", 3'b101, 0, 0, exp_cnt(0));

      send_frame("perr", 6'b010111);
      expect_frame("perr", 3'b101, 1, 0, exp_cnt(1));

      send_frame("ferr", 6'b011000);
      expect_frame("ferr", 3'b011, 0, 1, exp_cnt(2));

      // Strobe every 4th cycle, sdi toggling between strobes.
      gap_bits = 6'b001101;
      dv_count = 0;
      for (int i = 0; i < 6; i++) begin
         repeat (3) begin
            @(negedge clk);
            if (data_valid) dv_count++;
            bit_en = 1'b0;
            sdi    = ~sdi;
         end
         @(negedge clk);
         if (data_valid) dv_count++;
         bit_en = 1'b1;
         sdi    = gap_bits[5-i];
      end
      repeat (8) begin
         @(negedge clk);
         if (data_valid) dv_count++;
         bit_en = 1'b0;
         sdi    = ~sdi;
      end
      check("gap_dv_count", dv_count, 1);
      check("gap_data", int'(data_out), 3'b110);
      check("gap_perr", int'(parity_err), 0);
      check("gap_ferr", int'(frame_err), 0);
      check("gap_cnt", int'(err_cnt), exp_cnt(2));

      // Reset after d1 of a frame.
      sdi = 1'b1;
      @(negedge clk); bit_en = 1'b1; sdi = 1'b0;
      @(negedge clk); sdi = 1'b1;
      @(negedge clk); sdi = 1'b0;
      @(negedge clk); bit_en = 1'b0; sdi = 1'b1;
      rst = 1'b1;
      #1;
      check("mid_rst_data", int'(data_out),   0);
      check("mid_rst_dv",   int'(data_valid), 0);
      check("mid_rst_flags", int'({parity_err, frame_err}), 0);
      check("mid_rst_cnt",  int'(err_cnt),    0);
      @(negedge clk);
      rst = 1'b0;
      send_frame("after_rst", 6'b011111);
      expect_frame("after_rst", 3'b111, 0, 0, 0);

      // Five back-to-back parity-error frames, no idle bits between them.
      sat_bits = {5{6'b010111}};
      pulses   = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (data_valid) begin
            pulses++;
            check("sat_cnt_step", int'(err_cnt), exp_cnt(pulses));
            check("sat_perr_step", int'(parity_err), 1);
         end
         bit_en = 1'b1;
         sdi    = sat_bits[29-i];
      end
      @(negedge clk);
      bit_en = 1'b0;
      sdi    = 1'b1;
      if (data_valid) pulses++;
      check("sat_pulses", pulses, 5);
      check("sat_cnt", int'(err_cnt), exp_cnt(5));
      check("sat_data", int'(data_out), 3'b101);
      check("sat_perr", int'(parity_err), 1);
      check("sat_ferr", int'(frame_err), 0);
      @(negedge clk);
      check("sat_dv_off", int'(data_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/parity_frame_receiver.md
# parity_frame_receiver

Serial receiver that sits directly downstream of the 3-bit even-parity generator/checker stage. It accepts a start/data/parity/stop framed bit stream, deserializes the data word, and re-checks even parity over data plus parity bit. It presents the word with a one-cycle valid strobe and parity/framing error flags. An optional saturating error counter accumulates bad frames for diagnostics.

## Interface
- DATA_W, 3, data bits per frame (matches the 3-bit parity generator)
- ERR_CNT_W, 8, width of error counter (used only with PARITY_ERR_CNT_EN)

- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- bit_en  input  1  bit strobe; sdi is sampled only on edges where bit_en=1
- sdi  input  1  serial data in; idle level 1
- data_out  output  DATA_W  last received data word, x_1 in bit 0; held until next frame completes
- data_valid  output  1  one-clock pulse: data_out/flags updated
- parity_err  output  1  1 = XOR of received data and parity bit is 1 (odd); held with data_out
- frame_err  output  1  1 = stop bit sampled as 0; held with data_out
- err_cnt  output  ERR_CNT_W  saturating count of frames with parity_err or frame_err (macro-dependent)

## Operation
- Frame, in sample order: start (0), d0..d(DATA_W-1) LSB first, parity p, stop (1).
- Even parity: a good frame has d0^...^d(DATA_W-1)^p = 0.
- FSM states IDLE, DATA, PARITY, STOP; bit counter sized for DATA_W-1; data shift register DATA_W bits.
- IDLE: on bit_en & sdi=0 -> DATA, bit counter cleared. bit_en & sdi=1 -> stay.
- DATA: on each bit_en, store sdi at bit index = counter, counter+1. After DATA_W-th sample -> PARITY.
- PARITY: on bit_en, capture sdi as p -> STOP.
- STOP: on bit_en:
  - data_out <= shift register
  - parity_err <= ^shift register ^ p
  - frame_err <= ~sdi
  - data_valid <= 1
  - -> IDLE
- A bad stop bit still delivers the word (frame_err=1). The 0 stop bit is not reused as a start bit.
- No bit_en: FSM, counter and shift register hold. No timeout.
- Any state other than the four listed -> IDLE.
- err_cnt increments by 1 on the same edge that sets data_valid, if parity_err|frame_err for that frame. It holds at 2^ERR_CNT_W-1.

## Timing
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, err_cnt=0, state IDLE, counter 0, shift register 0.
- Reset acts immediately and asynchronously. Mid-frame reset discards the partial frame; the next start bit after release begins a fresh frame.
- Frame length is DATA_W+3 bit_en samples (6 at default).
- Latency: outputs become valid in the cycle immediately after the edge that samples stop (registered outputs). data_valid is high for exactly one clock, then 0.
- bit_en high in every cycle is legal; back-to-back frames need no idle bit. The start bit may be sampled on the bit_en immediately after stop.
- data_out, parity_err and frame_err change only when data_valid pulses.

## Configuration
- PARITY_ERR_CNT_EN defined: err_cnt counter built as described.
- PARITY_ERR_CNT_EN undefined: no counter logic; err_cnt tied to 0. Port list is unchanged.

## Test plan
- Reset, then sdi held 1 with bit_en=1 for 20 cycles -> data_valid never asserts; all outputs 0.
- Good frame, bit_en every cycle: sdi 0,1,0,1,0,1 -> data_out=3'b101, parity_err=0, frame_err=0, single-cycle data_valid one clock after stop; err_cnt=0.
- Parity error frame: sdi 0,1,0,1,1,1 -> data_out=3'b101, parity_err=1, err_cnt=1. Then stop=0 frame 0,1,1,0,0,0 -> data_out=3'b011, parity_err=0, frame_err=1, err_cnt=2.
- Gapped strobe: bit_en=1 every 4th cycle, sdi 0,0,1,1,0,1 with sdi toggling on non-strobe cycles -> data_out=3'b110, no errors, exactly one data_valid.
- Reset mid-frame: assert rst after d1 of a frame -> outputs 0 immediately. After release, frame 0,1,1,1,1,1 -> data_out=3'b111, parity_err=0.
- Saturation with ERR_CNT_W=2 and macro defined: 5 consecutive parity-error frames -> err_cnt=3. With macro undefined, the same stimulus leaves err_cnt=0 with flags still set.
